divide_issue_ctrl: RTL and testbench

//  Issue/return controller in front of the iterative 64-bit divider in EXU.

---
 rtl/divide_issue_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_divide_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divide_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : divide_issue_ctrl
//  Purpose  : Issue/return controller for the iterative 64-bit EXU divider.
//             Launches one divider run per RV64M divide-class op, selects the
//             quotient or remainder, sign-extends W results and presents the
//             result on a valid/ready port to writeback. Handles flush,
//             including draining a divider run that cannot be aborted.
//  Options  : DIV_RESULT_REUSE_EN - one-entry result store; a request whose
//             operands/mode match the stored run is answered without the divider.
//  Revision : 1.0 - initial release
// ============================================================================
module divide_issue_ctrl #(
    parameter int XLEN = 64,
    parameter int RDW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    // request from execute
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [RDW-1:0]  req_rd,
    // divider interface
    output logic            div_valid,
    output logic            div_sign,
    output logic            div_word,
    output logic [XLEN-1:0] div_x,
    output logic [XLEN-1:0] div_y,
    input  logic            div_data_ok,
    input  logic [XLEN-1:0] div_data,
    input  logic [XLEN-1:0] rem_data,
    // response to writeback
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [RDW-1:0]  rsp_rd,
    output logic            busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]      state_q, state_d;
    logic            rem_sel_q, rem_sel_d;
    logic            sign_q, sign_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] x_q, x_d;
    logic [XLEN-1:0] y_q, y_d;
    logic [RDW-1:0]  rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;

    logic            w_accept;
    logic            w_hit;
    logic [XLEN-1:0] w_hit_data;
    logic            w_unused_f3;

    // funct3[2] only distinguishes MUL from DIV upstream; it carries no meaning here.
    assign w_unused_f3 = req_funct3[2];

    // W results are always sign-extended from bit 31, unsigned forms included.
    function automatic logic [XLEN-1:0] ext_res(input logic [XLEN-1:0] r, input logic w);
        ext_res = w ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
    endfunction

    // Accepting is only possible in IDLE; flush and reset both close the door.
    assign req_ready = (state_q == S_IDLE) && !flush && !rst;
    assign w_accept  = req_valid && req_ready;

`ifdef DIV_RESULT_REUSE_EN
    logic            ent_v_q;
    logic [XLEN-1:0] ent_x_q, ent_y_q, ent_quot_q, ent_rem_q;
    logic            ent_sign_q, ent_word_q;
    logic            w_store;

    // Every divider completion in WAIT is a trustworthy result; DRAIN never stores.
    assign w_store = (state_q == S_WAIT) && div_data_ok;

    assign w_hit = ent_v_q && (ent_x_q == req_rs1) && (ent_y_q == req_rs2) &&
                   (ent_sign_q == !req_funct3[0]) && (ent_word_q == req_word);
    assign w_hit_data = ext_res(req_funct3[1] ? ent_rem_q : ent_quot_q, req_word);

    // Result store: refreshed on each completed run, invalidated only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_v_q    <= 1'b0;
            ent_x_q    <= '0;
            ent_y_q    <= '0;
            ent_quot_q <= '0;
            ent_rem_q  <= '0;
            ent_sign_q <= 1'b0;
            ent_word_q <= 1'b0;
        end else if (w_store) begin
            ent_v_q    <= 1'b1;
            ent_x_q    <= x_q;
            ent_y_q    <= y_q;
            ent_quot_q <= div_data;
            ent_rem_q  <= rem_data;
            ent_sign_q <= sign_q;
            ent_word_q <= word_q;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    // Next-state logic for the issue/return FSM and the operand/result registers.
    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        sign_d    = sign_q;
        word_d    = word_q;
        x_d       = x_q;
        y_d       = y_q;
        rd_d      = rd_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    rem_sel_d = req_funct3[1];
                    sign_d    = !req_funct3[0];
                    word_d    = req_word;
                    x_d       = req_rs1;
                    y_d       = req_rs2;
                    rd_d      = req_rd;
                    if (w_hit) begin
                        data_d  = w_hit_data;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // A flush here suppresses the start pulse, so nothing is left running.
                state_d = S_IDLE;
                if (!flush) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_data_ok) begin
                    // Completion coincident with flush leaves nothing to drain.
                    data_d  = ext_res(rem_sel_q ? rem_data : div_data, word_q);
                    state_d = flush ? S_IDLE : S_RESP;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_sel_q <= 1'b0;
            sign_q    <= 1'b0;
            word_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            rem_sel_q <= rem_sel_d;
            sign_q    <= sign_d;
            word_q    <= word_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    assign div_valid = (state_q == S_ISSUE) && !flush;
    assign div_sign  = sign_q;
    assign div_word  = word_q;
    assign div_x     = x_q;
    assign div_y     = y_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = data_q;
    assign rsp_rd    = rd_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_divide_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divide_issue_ctrl
//  Purpose  : Self-checking bench for divide_issue_ctrl; the divider is
//             modelled by the bench, returning hand-written quotient/remainder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_divide_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = '0;
    logic        req_word = 1'b0;
    logic [63:0] req_rs1 = '0;
    logic [63:0] req_rs2 = '0;
    logic [4:0]  req_rd = '0;
    logic        div_valid, div_sign, div_word;
    logic [63:0] div_x, div_y;
    logic        div_data_ok = 1'b0;
    logic [63:0] div_data = '0;
    logic [63:0] rem_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // bench-side model of the reuse store (only consulted in the reuse build)
    logic        m_valid = 1'b0;
    logic [63:0] m_rs1 = '0, m_rs2 = '0;
    logic        m_sign = 1'b0, m_word = 1'b0;

    typedef struct {
        logic [2:0]  f3;
        logic        word;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [4:0]  rd;
        logic [63:0] dq;    // quotient the modelled divider returns
        logic [63:0] dr;    // remainder the modelled divider returns
        logic [63:0] exp;   // required rsp_data
        int          hold;  // cycles rsp_ready is held low in RESP
    } vec_t;

    vec_t vecs[6];

    divide_issue_ctrl #(.XLEN(64), .RDW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_word(req_word), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .div_valid(div_valid), .div_sign(div_sign), .div_word(div_word),
        .div_x(div_x), .div_y(div_y), .div_data_ok(div_data_ok),
        .div_data(div_data), .rem_data(rem_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " div_valid"}, {63'd0, div_valid}, 64'd0);
        check({tag, " rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, " busy"}, {63'd0, busy}, 64'd0);
        check({tag, " req_ready"}, {63'd0, req_ready}, 64'd0);
        check({tag, " rsp_data"}, rsp_data, 64'd0);
        check({tag, " rsp_rd"}, {59'd0, rsp_rd}, 64'd0);
        check({tag, " div_x"}, div_x, 64'd0);
        check({tag, " div_y"}, div_y, 64'd0);
        check({tag, " div_sign/word"}, {62'd0, div_sign, div_word}, 64'd0);
    endtask

    // Present one request at a negedge; returns at the negedge after acceptance.
    task automatic accept(input vec_t v);
        req_valid  = 1'b1;
        req_funct3 = v.f3;
        req_word   = v.word;
        req_rs1    = v.rs1;
        req_rs2    = v.rs2;
        req_rd     = v.rd;
        #1;
        check("req_ready idle", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Full op: accept, divider run (or reuse hit), response with optional backpressure.
    task automatic run_op(input vec_t v);
        logic hit;
        hit = 1'b0;
`ifdef DIV_RESULT_REUSE_EN
        hit = m_valid && (m_rs1 == v.rs1) && (m_rs2 == v.rs2) &&
              (m_sign == !v.f3[0]) && (m_word == v.word);
`endif
        accept(v);
        if (!hit) begin
            check("div_valid T+1", {63'd0, div_valid}, 64'd1);
            check("div_x", div_x, v.rs1);
            check("div_y", div_y, v.rs2);
            check("div_sign", {63'd0, div_sign}, {63'd0, !v.f3[0]});
            check("div_word", {63'd0, div_word}, {63'd0, v.word});
            check("req_ready busy", {63'd0, req_ready}, 64'd0);
            @(negedge clk);
            check("div_valid one pulse", {63'd0, div_valid}, 64'd0);
            repeat (2) @(negedge clk);
            check("rsp_valid in wait", {63'd0, rsp_valid}, 64'd0);
            check("busy in wait", {63'd0, busy}, 64'd1);
            div_data_ok = 1'b1;
            div_data    = v.dq;
            rem_data    = v.dr;
            @(negedge clk);
            div_data_ok = 1'b0;
            div_data    = '0;
            rem_data    = '0;
            m_valid = 1'b1;
            m_rs1   = v.rs1;
            m_rs2   = v.rs2;
            m_sign  = !v.f3[0];
            m_word  = v.word;
        end
        check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("rsp_data", rsp_data, v.exp);
        check("rsp_rd", {59'd0, rsp_rd}, {59'd0, v.rd});
        check("no div_valid in resp", {63'd0, div_valid}, 64'd0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check("hold rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold rsp_data", rsp_data, v.exp);
            check("hold rsp_rd", {59'd0, rsp_rd}, {59'd0, v.rd});
            check("hold req_ready", {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid after ready", {63'd0, rsp_valid}, 64'd0);
        check("busy after ready", {63'd0, busy}, 64'd0);
    endtask

    vec_t t;

    initial begin
        //            f3    w     rs1                     rs2                     rd     dq                      dr                      exp                     hold
        vecs[0] = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 5'd3,  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 0};
        vecs[1] = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 5'd4,  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0};
        vecs[2] = '{3'b101, 1'b0, 64'd5,                  64'd0,                 5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'd5,                  64'hFFFF_FFFF_FFFF_FFFF, 0};
        vecs[3] = '{3'b111, 1'b0, 64'd5,                  64'd0,                 5'd6,  64'hFFFF_FFFF_FFFF_FFFF, 64'd5,                  64'd5,                  5};
        vecs[4] = '{3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,                 5'd17, 64'h0000_0000_FFFF_FFFF, 64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 0};
        vecs[5] = '{3'b111, 1'b1, 64'h0000_0000_8000_0003, 64'h10,                5'd31, 64'h0000_0000_0800_0000, 64'd3,                  64'd3,                  0};

        // reset state
        @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("req_ready after reset", {63'd0, req_ready}, 64'd1);

        // table-driven ops
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i]);
        end

        // flush while in ISSUE: no start pulse, straight back to idle
        t = '{3'b100, 1'b0, 64'd8, 64'd4, 5'd1, 64'd2, 64'd0, 64'd2, 0};
        accept(t);
        flush = 1'b1;
        #1;
        check("issue flush no pulse", {63'd0, div_valid}, 64'd0);
        @(negedge clk);
        flush = 1'b0;
        check("issue flush busy", {63'd0, busy}, 64'd0);
        check("issue flush rsp_valid", {63'd0, rsp_valid}, 64'd0);

        // flush 3 cycles after div_valid: drain until divider completes
        t = '{3'b100, 1'b0, 64'd100, 64'd7, 5'd9, 64'd14, 64'd2, 64'd14, 0};
        accept(t);
        check("drain div_valid", {63'd0, div_valid}, 64'd1);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain busy", {63'd0, busy}, 64'd1);
            check("drain rsp_valid", {63'd0, rsp_valid}, 64'd0);
            @(negedge clk);
        end
        div_data_ok = 1'b1;
        div_data    = 64'd14;
        rem_data    = 64'd2;
        @(negedge clk);
        div_data_ok = 1'b0;
        div_data    = '0;
        rem_data    = '0;
        check("drain done busy", {63'd0, busy}, 64'd0);
        check("drain done rsp_valid", {63'd0, rsp_valid}, 64'd0);

        // DIV 100/7 then REM 100/7 (reuse hit when the store is built in)
        run_op(t);
        t = '{3'b110, 1'b0, 64'd100, 64'd7, 5'd10, 64'd14, 64'd2, 64'd2, 0};
        run_op(t);

        // flush in RESP wins over rsp_ready
        t = '{3'b100, 1'b0, 64'd9, 64'd3, 5'd2, 64'd3, 64'd0, 64'd3, 0};
        accept(t);
        @(negedge clk);
        div_data_ok = 1'b1;
        div_data    = 64'd3;
        @(negedge clk);
        div_data_ok = 1'b0;
        div_data    = '0;
        m_valid = 1'b1; m_rs1 = 64'd9; m_rs2 = 64'd3; m_sign = 1'b1; m_word = 1'b0;
        check("resp before flush", {63'd0, rsp_valid}, 64'd1);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        rsp_ready = 1'b0;
        check("resp flush rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("resp flush busy", {63'd0, busy}, 64'd0);

        // reset asserted in WAIT
        t = '{3'b100, 1'b1, 64'd100, 64'd3, 5'd7, 64'd33, 64'd1, 64'd33, 0};
        accept(t);
        @(negedge clk);
        check("pre-reset busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst in wait");
        rst = 1'b0;
        m_valid = 1'b0;

        // divider done pulse while idle is ignored
        @(negedge clk);
        div_data_ok = 1'b1;
        div_data    = 64'hDEAD;
        @(negedge clk);
        div_data_ok = 1'b0;
        div_data    = '0;
        check("stray ok rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("stray ok busy", {63'd0, busy}, 64'd0);

        // store cleared by reset: REM 100/7 runs the divider
        t = '{3'b110, 1'b0, 64'd100, 64'd7, 5'd11, 64'd14, 64'd2, 64'd2, 0};
        run_op(t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
